regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single write port of the register bank between
//   NUM_REQ requesters. The bank is built from write-enabled flip-flop cells (clk, data, write -> q).
//   Accepted requests are registered onto wr_en/wr_addr/wr_data, one write per cycle.
//   wr_en drives the bank's per-cell write-enable decode.
// PARAMETERS
//   NUM_REQ      4   number of requesters (2..8)
//   ADDR_W       5   register address width
//   DATA_W       32  register data width
//   ZERO_REG_RO  1   1: writes to address 0 are accepted but dropped (hard-wired zero register)
// PORTS
//   clk        in   1                 single clock, rising edge
//   rst_n      in   1                 asynchronous, active-low reset
//   stall      in   1                 1: no grants this cycle (bank busy / read-locked)
//   req        in   NUM_REQ           per-requester write request, level
//   req_addr   in   NUM_REQ*ADDR_W    flattened; requester i occupies [i*ADDR_W +: ADDR_W]
//   req_data   in   NUM_REQ*DATA_W    flattened; requester i occupies [i*DATA_W +: DATA_W]
//   gnt        out  NUM_REQ           one-hot grant, combinational; transfer = req[i] & gnt[i] at clk edge
//   wr_en      out  1                 registered write enable to register bank
//   wr_addr    out  ADDR_W            registered write address
//   wr_data    out  DATA_W            registered write data
//   busy       out  1                 registered; 1 if any req was high and not granted last cycle
// BEHAVIOUR
//   - Reset (rst_n=0, async): wr_en=0, wr_addr=0, wr_data=0, busy=0, ptr=0; gnt forced to 0 while rst_n=0.
//   - ptr (clog2(NUM_REQ) bits) = highest-priority index; search order ptr, ptr+1, ... mod NUM_REQ.
//   - gnt: at most one bit set; gnt=0 when stall=1 or req=0; otherwise first req[i]=1 in search order.
//   - Handshake: requester holds req/addr/data stable until it sees gnt[i]=1.
//     A transfer completes at the edge where req[i]&gnt[i]=1.
//     Requester may keep req high with new addr/data for back-to-back writes.
//   - Latency: transfer at edge k -> wr_en=1, wr_addr/wr_data = that requester's values, during cycle k..k+1.
//     Bank captures at edge k+1. No transfer at edge k -> wr_en=0; wr_addr/wr_data hold last value.
//   - ptr update: on transfer from index g, ptr <= (g+1) mod NUM_REQ.
//     No transfer (idle or stall) -> ptr holds.
//   - Fairness: with all requesters continuously asserting, each requester is granted once every NUM_REQ cycles.
//     A lone requester is granted every cycle.
//   - ZERO_REG_RO=1 and granted addr==0: gnt pulses, ptr advances, wr_en stays 0 for that write.
//     wr_addr/wr_data still update.
//   - stall: combinationally blocks gnt in the same cycle; pending req stay pending.
//     On stall release, arbitration resumes from the held ptr.
//   - busy <= |(req & ~gnt) each cycle (0 while stall=0 with a single requester).
//   - Reset mid-operation: an in-flight registered write is discarded (wr_en=0 immediately, async).
//     First post-reset grant goes to requester 0 if requesting.
//   - Simultaneous req rise on several requesters: only search-order winner granted; others wait.
//     No combinational path from req_addr/req_data to gnt.
// TESTING
//   1 Reset: req=4'b1111 running, assert rst_n=0 mid-cycle -> wr_en=0 and gnt=0 at once;
//     release -> first gnt=4'b0001, wr_en=1 next cycle.
//   2 All four req held high, addr_i=i+1, data_i=32'hA0+i -> gnt sequence 0001,0010,0100,1000,0001.
//     wr_addr 1,2,3,4,1 each one cycle later.
//   3 Only req[2], addr 5 then 6 on consecutive cycles, data 32'h1234/32'h5678 -> gnt[2]=1 both cycles.
//     wr_en=1 two cycles with (5,1234) then (6,5678).
//   4 ZERO_REG_RO=1, req[1] addr 0 data 32'hFFFF_FFFF -> gnt=0010, wr_en stays 0, ptr becomes 2.
//   5 req=0011 with stall=1 for 3 cycles -> gnt=0, wr_en=0, busy=1.
//     stall=0 -> gnt=0001 then 0010.
//   6 ptr=2 (after granting 1), req=1010 -> gnt=1000 first, then 0010.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the register bank.
// master: requester/bank side; slave: arbiter side.
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
);
   logic                      stall;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic                      wr_en;
   logic [ADDR_W-1:0]         wr_addr;
   logic [DATA_W-1:0]         wr_data;
   logic                      busy;

   modport master (
      output stall, req, req_addr, req_data,
      input  gnt, wr_en, wr_addr, wr_data, busy
   );

   modport slave (
      input  stall, req, req_addr, req_data,
      output gnt, wr_en, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port among NUM_REQ requesters.
// Ports: clk, rst_n (async active-low), bus (slave: stall/req/addr/data in; gnt/wr_*/busy out).
module regfile_write_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter bit ZERO_REG_RO = 1'b1
) (
   input logic                    clk,
   input logic                    rst_n,
   regfile_write_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   gidx;
   logic [PTR_W:0]     sum;
   logic [NUM_REQ-1:0] gnt_c;
   logic               found;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic               busy_q, busy_d;

   // Search ptr, ptr+1, ... with wrap; grant is forced low in reset
   // and during stall. Only req and ptr feed the grant.
   always_comb begin
      gnt_c = '0;
      gidx  = '0;
      found = 1'b0;
      sum   = '0;
      if (rst_n && !bus.stall) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
               sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && bus.req[sum[PTR_W-1:0]]) begin
               found = 1'b1;
               gidx  = sum[PTR_W-1:0];
               gnt_c[sum[PTR_W-1:0]] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_c[k]) begin
            sel_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
            sel_data = bus.req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = |(bus.req & ~gnt_c);
      if (found) begin
         ptr_d     = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
         wr_addr_d = sel_addr;
         wr_data_d = sel_data;
         // Address 0 is the hard-wired zero register: consume, don't write.
         wr_en_d   = !(ZERO_REG_RO && (sel_addr == '0));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.gnt     = gnt_c;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (NUM_REQ=4, ADDR_W=5, DATA_W=32).
// Expected writes are queued when a grant is expected and popped after the edge.
module tb_regfile_write_arbiter;
   typedef struct packed {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   logic [4:0]  a_tb [4];
   logic [31:0] d_tb [4];
   wr_t         exp_q [$];
   logic [4:0]  last_a;
   logic [31:0] last_d;

   regfile_write_arbiter_if #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32)) rf_if ();

   regfile_write_arbiter #(
      .NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .ZERO_REG_RO(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(rf_if)
   );

   always #5 clk = ~clk;

   always_comb begin
      rf_if.req_addr = '0;
      rf_if.req_data = '0;
      for (int i = 0; i < 4; i++) begin
         rf_if.req_addr[i*5 +: 5]   = a_tb[i];
         rf_if.req_data[i*32 +: 32] = d_tb[i];
      end
   end

   // Model of the bank write that an expected grant g must produce.
   task automatic push_exp(input logic [3:0] g);
      wr_t e;
      e = '{en: 1'b0, addr: last_a, data: last_d};
      for (int i = 0; i < 4; i++) begin
         if (g[i]) begin
            e.addr = a_tb[i];
            e.data = d_tb[i];
            e.en   = (a_tb[i] != 5'd0);
         end
      end
      last_a = e.addr;
      last_d = e.data;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rf_if.req   = '0;
      rf_if.stall = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      last_a = '0;
      last_d = '0;
   endtask

   task automatic set_ramp();
      for (int i = 0; i < 4; i++) begin
         a_tb[i] = 5'(i + 1);
         d_tb[i] = 32'hA0 + 32'(i);
      end
   endtask

   task automatic test_reset();
      logic [3:0] g [2];
      wr_t e;
      g = '{4'b0001, 4'b0010};
      set_ramp();
      rf_if.req = 4'b1111;
      #1;
      checks++;
      if ({rf_if.gnt, rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data, rf_if.busy} !== '0) begin
         failures++;
         $display("FAIL rst_state: gnt=%b en=%b addr=%0d data=%h busy=%b want all 0",
                  rf_if.gnt, rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data, rf_if.busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      last_a = '0;
      last_d = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (rf_if.gnt !== g[c]) begin
            failures++;
            $display("FAIL rst_gnt c%0d: got %b want %b", c, rf_if.gnt, g[c]);
         end
         push_exp(g[c]);
         @(posedge clk); #1;
         checks++;
         e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
         if ({rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data} !== e) begin
            failures++;
            $display("FAIL rst_wr c%0d: got %h want %h", c,
                     {rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data}, e);
         end
      end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rf_if.wr_en !== 1'b0 || rf_if.gnt !== 4'b0000) begin
         failures++;
         $display("FAIL rst_mid: en=%b gnt=%b want 0 and 0000", rf_if.wr_en, rf_if.gnt);
      end
      exp_q.delete();
      last_a = '0;
      last_d = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rf_if.gnt !== 4'b0001) begin
         failures++;
         $display("FAIL rst_first_gnt: got %b want 0001", rf_if.gnt);
      end
      push_exp(4'b0001);
      @(posedge clk); #1;
      checks++;
      e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
      if ({rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data} !== e) begin
         failures++;
         $display("FAIL rst_first_wr: got %h want %h",
                  {rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data}, e);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] g [5];
      wr_t e;
      g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      set_ramp();
      rf_if.req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (rf_if.gnt !== g[c]) begin
            failures++;
            $display("FAIL rr_gnt c%0d: got %b want %b", c, rf_if.gnt, g[c]);
         end
         push_exp(g[c]);
         @(posedge clk); #1;
         checks++;
         e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
         if ({rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data} !== e) begin
            failures++;
            $display("FAIL rr_wr c%0d: got %h want %h", c,
                     {rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data}, e);
         end
         checks++;
         if (rf_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL rr_busy c%0d: got %b want 1", c, rf_if.busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  r [3];
      logic [3:0]  g [3];
      logic [4:0]  a [3];
      logic [31:0] d [3];
      wr_t e;
      r = '{4'b0100, 4'b0100, 4'b0000};
      g = '{4'b0100, 4'b0100, 4'b0000};
      a = '{5'd5, 5'd6, 5'd6};
      d = '{32'h1234, 32'h5678, 32'h5678};
      do_reset();
      for (int c = 0; c < 3; c++) begin
         rf_if.req = r[c];
         a_tb[2] = a[c];
         d_tb[2] = d[c];
         @(negedge clk);
         checks++;
         if (rf_if.gnt !== g[c]) begin
            failures++;
            $display("FAIL b2b_gnt c%0d: got %b want %b", c, rf_if.gnt, g[c]);
         end
         push_exp(g[c]);
         @(posedge clk); #1;
         checks++;
         e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
         if ({rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data} !== e) begin
            failures++;
            $display("FAIL b2b_wr c%0d: got %h want %h", c,
                     {rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data}, e);
         end
         checks++;
         if (rf_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy c%0d: got %b want 0", c, rf_if.busy);
         end
      end
   endtask

   task automatic test_zero_reg();
      logic [3:0] r [3];
      logic [3:0] g [3];
      wr_t e;
      r = '{4'b0010, 4'b0110, 4'b0110};
      g = '{4'b0010, 4'b0100, 4'b0010};
      do_reset();
      a_tb[1] = 5'd0;
      d_tb[1] = 32'hFFFF_FFFF;
      for (int c = 0; c < 3; c++) begin
         rf_if.req = r[c];
         if (c == 1) begin
            a_tb[1] = 5'd8;
            d_tb[1] = 32'h11;
            a_tb[2] = 5'd7;
            d_tb[2] = 32'h22;
         end
         @(negedge clk);
         checks++;
         if (rf_if.gnt !== g[c]) begin
            failures++;
            $display("FAIL zero_gnt c%0d: got %b want %b", c, rf_if.gnt, g[c]);
         end
         push_exp(g[c]);
         @(posedge clk); #1;
         checks++;
         e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
         if ({rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data} !== e) begin
            failures++;
            $display("FAIL zero_wr c%0d: got %h want %h", c,
                     {rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data}, e);
         end
      end
   endtask

   task automatic test_stall();
      logic       s [5];
      logic [3:0] g [5];
      wr_t e;
      s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      g = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
      do_reset();
      set_ramp();
      rf_if.req = 4'b0011;
      for (int c = 0; c < 5; c++) begin
         rf_if.stall = s[c];
         @(negedge clk);
         checks++;
         if (rf_if.gnt !== g[c]) begin
            failures++;
            $display("FAIL stall_gnt c%0d: got %b want %b", c, rf_if.gnt, g[c]);
         end
         push_exp(g[c]);
         @(posedge clk); #1;
         checks++;
         e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
         if ({rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data} !== e) begin
            failures++;
            $display("FAIL stall_wr c%0d: got %h want %h", c,
                     {rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data}, e);
         end
         checks++;
         if (rf_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_busy c%0d: got %b want 1", c, rf_if.busy);
         end
      end
      rf_if.stall = 1'b0;
   endtask

   task automatic test_ptr_wrap();
      logic [3:0] r [3];
      logic [3:0] g [3];
      wr_t e;
      r = '{4'b0010, 4'b1010, 4'b1010};
      g = '{4'b0010, 4'b1000, 4'b0010};
      do_reset();
      a_tb[1] = 5'd3;
      d_tb[1] = 32'hBEEF;
      a_tb[3] = 5'd9;
      d_tb[3] = 32'hCAFE;
      for (int c = 0; c < 3; c++) begin
         rf_if.req = r[c];
         @(negedge clk);
         checks++;
         if (rf_if.gnt !== g[c]) begin
            failures++;
            $display("FAIL ptr_gnt c%0d: got %b want %b", c, rf_if.gnt, g[c]);
         end
         push_exp(g[c]);
         @(posedge clk); #1;
         checks++;
         e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
         if ({rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data} !== e) begin
            failures++;
            $display("FAIL ptr_wr c%0d: got %h want %h", c,
                     {rf_if.wr_en, rf_if.wr_addr, rf_if.wr_data}, e);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      rf_if.req   = '0;
      rf_if.stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_tb[i] = '0;
         d_tb[i] = '0;
      end
      last_a = '0;
      last_d = '0;
      #2;
      rst_n = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_round_robin();
      test_back_to_back();
      test_zero_reg();
      test_stall();
      test_ptr_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
